// File: rtl/brq_pkg.sv
// Shared types and sizing helpers for the branch resolve queue.
package brq_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic        pred_taken;
      logic [31:0] pred_target;
   } brq_entry_t;

   localparam int BRQ_DEF_DEPTH = 4;

   function automatic int brq_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int BRQ_PTR_W = brq_ptr_w(BRQ_DEF_DEPTH);

endpackage

// File: rtl/brq_fifo.sv
// Circular FIFO of in-flight branch entries with push/pop/clear and an occupancy count.
module brq_fifo
   import brq_pkg::*;
#(
   parameter int  DEPTH = BRQ_DEF_DEPTH,
   parameter type T     = brq_entry_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   input  logic clear,
   output T     head_data,
   output logic full,
   output logic empty
);

   localparam int PTR_W = (DEPTH == BRQ_DEF_DEPTH) ? BRQ_PTR_W : brq_ptr_w(DEPTH);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [PTR_W:0]   count_q;

   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign head_data = mem[head_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (clear) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[tail_q] <= push_data;
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks predicted branches in program order, retires them on resolve, drives BHT
// update and mispredict redirect, and keeps saturating performance counters.
module branch_resolve_queue
   import brq_pkg::*;
#(
   parameter int DEPTH     = BRQ_DEF_DEPTH,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push_en,
   input  logic [31:0]          push_pc,
   input  logic                 push_pred_taken,
   input  logic [31:0]          push_pred_target,
   output logic                 brq_full,
   input  logic                 resolve_en,
   input  logic                 resolve_taken,
   input  logic [31:0]          resolve_target,
   input  logic                 flush,
   output logic                 update_en,
   output logic [31:0]          update_pc,
   output logic                 update_actual_taken,
   output logic                 redirect_en,
   output logic [31:0]          redirect_pc,
   output logic                 protocol_err,
   output logic [CNT_WIDTH-1:0] branch_cnt,
   output logic [CNT_WIDTH-1:0] mispred_cnt
);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   brq_entry_t head;
   brq_entry_t push_entry;
   logic       fifo_full;
   logic       fifo_empty;
   logic       resolve_ok;
   logic       mispred;
   logic       squash;
   logic       push_room;
   logic       push_ok;
   logic       err_set;
   logic       fifo_clear;

   assign push_entry = '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};
   assign brq_full   = fifo_full;

   // Flush outranks everything; a mispredict squashes the whole queue including a same-cycle push.
   always_comb begin
      resolve_ok = resolve_en && !flush && !fifo_empty;
      mispred    = (resolve_taken != head.pred_taken) ||
                   (resolve_taken && (resolve_target != head.pred_target));
      squash     = resolve_ok && mispred;
      push_room  = !fifo_full || resolve_ok;
      push_ok    = push_en && !flush && push_room && !squash;
      err_set    = !flush && ((push_en && !push_room) || (resolve_en && fifo_empty));
      fifo_clear = flush || squash;
   end

   brq_fifo #(
      .DEPTH (DEPTH),
      .T     (brq_entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_ok),
      .push_data (push_entry),
      .pop       (resolve_ok),
      .clear     (fifo_clear),
      .head_data (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Registered outcome stage: everything below appears one cycle after resolve_en.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         update_en           <= 1'b0;
         update_pc           <= '0;
         update_actual_taken <= 1'b0;
         redirect_en         <= 1'b0;
         redirect_pc         <= '0;
         protocol_err        <= 1'b0;
         branch_cnt          <= '0;
         mispred_cnt         <= '0;
      end else begin
         update_en   <= resolve_ok;
         redirect_en <= squash;
         if (resolve_ok) begin
            update_pc           <= head.pc;
            update_actual_taken <= resolve_taken;
            branch_cnt          <= sat_inc(branch_cnt);
         end
         if (squash) begin
            redirect_pc <= resolve_taken ? resolve_target : head.pc + 32'd4;
            mispred_cnt <= sat_inc(mispred_cnt);
         end
         if (err_set) protocol_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (DEPTH=4, CNT_WIDTH=4).
module tb_branch_resolve_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        push_en;
   logic [31:0] push_pc;
   logic        push_pred_taken;
   logic [31:0] push_pred_target;
   logic        brq_full;
   logic        resolve_en;
   logic        resolve_taken;
   logic [31:0] resolve_target;
   logic        flush;
   logic        update_en;
   logic [31:0] update_pc;
   logic        update_actual_taken;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        protocol_err;
   logic [3:0]  branch_cnt;
   logic [3:0]  mispred_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   branch_resolve_queue #(.DEPTH(4), .CNT_WIDTH(4)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .push_en             (push_en),
      .push_pc             (push_pc),
      .push_pred_taken     (push_pred_taken),
      .push_pred_target    (push_pred_target),
      .brq_full            (brq_full),
      .resolve_en          (resolve_en),
      .resolve_taken       (resolve_taken),
      .resolve_target      (resolve_target),
      .flush               (flush),
      .update_en           (update_en),
      .update_pc           (update_pc),
      .update_actual_taken (update_actual_taken),
      .redirect_en         (redirect_en),
      .redirect_pc         (redirect_pc),
      .protocol_err        (protocol_err),
      .branch_cnt          (branch_cnt),
      .mispred_cnt         (mispred_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push_en = 0; push_pc = 0; push_pred_taken = 0; push_pred_target = 0;
      resolve_en = 0; resolve_taken = 0; resolve_target = 0; flush = 0;
   endtask

   task automatic do_push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
      idle();
      push_en = 1; push_pc = pc; push_pred_taken = pt; push_pred_target = tgt;
      step();
      idle();
   endtask

   task automatic do_resolve(input logic t, input logic [31:0] tgt);
      idle();
      resolve_en = 1; resolve_taken = t; resolve_target = tgt;
      step();
      idle();
   endtask

   initial begin
      idle();
      rst_n = 0;
      step(); step();
      chk("rst_full", brq_full, 0);
      chk("rst_upd_en", update_en, 0);
      chk("rst_redir_en", redirect_en, 0);
      chk("rst_err", protocol_err, 0);
      chk("rst_bcnt", branch_cnt, 0);
      chk("rst_mcnt", mispred_cnt, 0);
      rst_n = 1;
      step();

      // 1: correctly predicted not-taken
      do_push(32'h100, 0, 32'h0);
      chk("t1_no_upd_yet", update_en, 0);
      do_resolve(0, 32'h0);
      chk("t1_upd_en", update_en, 1);
      chk("t1_upd_pc", update_pc, 32'h100);
      chk("t1_upd_tk", update_actual_taken, 0);
      chk("t1_redir_en", redirect_en, 0);
      chk("t1_bcnt", branch_cnt, 1);
      chk("t1_mcnt", mispred_cnt, 0);
      step();
      chk("t1_upd_pulse", update_en, 0);
      chk("t1_upd_pc_hold", update_pc, 32'h100);

      // 2: taken with wrong target
      do_push(32'h200, 1, 32'h240);
      do_resolve(1, 32'h280);
      chk("t2_redir_en", redirect_en, 1);
      chk("t2_redir_pc", redirect_pc, 32'h280);
      chk("t2_upd_tk", update_actual_taken, 1);
      chk("t2_mcnt", mispred_cnt, 1);
      chk("t2_bcnt", branch_cnt, 2);
      step();
      chk("t2_redir_pulse", redirect_en, 0);
      chk("t2_redir_pc_hold", redirect_pc, 32'h280);

      // 3: predicted taken, actually not taken; younger entry squashed
      do_push(32'h300, 1, 32'h400);
      do_push(32'h304, 0, 32'h0);
      do_resolve(0, 32'h0);
      chk("t3_redir_en", redirect_en, 1);
      chk("t3_redir_pc", redirect_pc, 32'h304);
      chk("t3_upd_pc", update_pc, 32'h300);
      chk("t3_full", brq_full, 0);
      chk("t3_mcnt", mispred_cnt, 2);
      chk("t3_bcnt", branch_cnt, 3);

      // 4: fill (also proves the squash left the queue empty)
      do_push(32'h10, 0, 0);
      do_push(32'h14, 0, 0);
      do_push(32'h18, 0, 0);
      chk("t4_not_full3", brq_full, 0);
      do_push(32'h1c, 0, 0);
      chk("t4_full4", brq_full, 1);
      idle();
      push_en = 1; push_pc = 32'h20; resolve_en = 1;
      step();
      idle();
      chk("t4_pr_upd_pc", update_pc, 32'h10);
      chk("t4_pr_full", brq_full, 1);
      chk("t4_pr_err", protocol_err, 0);
      do_push(32'h24, 0, 0);
      chk("t4_drop_err", protocol_err, 1);
      chk("t4_drop_full", brq_full, 1);
      do_resolve(0, 0);
      chk("t4_d0", update_pc, 32'h14);
      do_resolve(0, 0);
      chk("t4_d1", update_pc, 32'h18);
      do_resolve(0, 0);
      chk("t4_d2", update_pc, 32'h1c);
      do_resolve(0, 0);
      chk("t4_d3", update_pc, 32'h20);
      chk("t4_bcnt", branch_cnt, 8);
      chk("t4_empty_full", brq_full, 0);

      // reset mid-operation
      do_push(32'ha0, 0, 0);
      rst_n = 0; resolve_en = 1;
      step();
      idle();
      chk("mr_upd_en", update_en, 0);
      chk("mr_err", protocol_err, 0);
      chk("mr_bcnt", branch_cnt, 0);
      chk("mr_mcnt", mispred_cnt, 0);
      rst_n = 1;
      step();

      // 5: flush beats resolve and push
      do_push(32'h500, 0, 0);
      do_push(32'h504, 0, 0);
      idle();
      flush = 1; resolve_en = 1; push_en = 1; push_pc = 32'h508;
      step();
      idle();
      chk("t5_upd_en", update_en, 0);
      chk("t5_redir_en", redirect_en, 0);
      chk("t5_bcnt", branch_cnt, 0);
      chk("t5_mcnt", mispred_cnt, 0);
      chk("t5_err", protocol_err, 0);

      // 6: resolve on empty, then counter saturation
      do_resolve(0, 0);
      chk("t6_empty_err", protocol_err, 1);
      chk("t6_empty_upd", update_en, 0);
      chk("t6_empty_bcnt", branch_cnt, 0);
      for (int i = 0; i < 17; i++) begin
         do_push(32'h600 + 32'(i * 4), 0, 0);
         do_resolve(0, 0);
         chk("t6_upd_pc", update_pc, 32'h600 + 32'(i * 4));
         chk("t6_bcnt", branch_cnt, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      end
      chk("t6_mcnt", mispred_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
